pixel_stream_out: RTL

PIXEL_STREAM_OUT -- requirements
Module: pixel_stream_out

---
 rtl/pixel_stream_out_pkg.sv | 23 ++
 rtl/pixel_fifo.sv | 71 +++++++
 rtl/pixel_stream_out.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_out_pkg.sv
// Shared pixel and AXI4-Stream definitions for the pixel output path.
// Latency: n/a (types and helpers only). Backpressure: n/a.
package pixel_stream_out_pkg;

    localparam int         AXIS_DATA_W = 32;
    localparam logic [7:0] PIXEL_PAD   = 8'h00;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } ost_e;

    function automatic logic [AXIS_DATA_W-1:0] pack_axis(input rgb24_t pix);
        return {PIXEL_PAD, pix.r, pix.g, pix.b};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO exposing head and head+1 so the consumer can reload back-to-back.
// Latency: write visible at head one edge later. Backpressure: writes beyond full are ignored unless a read frees a slot that edge.
module pixel_fifo
    import pixel_stream_out_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = $bits(rgb24_t)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_dat_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_dat_o,
    output logic [W-1:0]             rd_nxt_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_nxt_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_nxt_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_rd;
    logic          do_wr;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

    // A read on the same edge frees the slot, so a full FIFO still accepts.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign rd_nxt_ptr   = rd_ptr_q + AW'(1);
    assign rd_dat_o     = mem_q[rd_ptr_q];
    assign rd_nxt_dat_o = mem_q[rd_nxt_ptr];
    assign count_o      = count_q;
    assign count_nxt_o  = count_d;

endmodule

// File: rtl/pixel_stream_out.sv
// Buffers 24-bit pixels and emits them as AXI4-Stream beats with SOF (tuser) and EOL (tlast) framing.
// Latency: 2 edges from valid_in to out_tvalid when empty. Backpressure: in_ready drops at FIFO_DEPTH-AFULL_MARGIN; pixels arriving at full are dropped and flagged.
module pixel_stream_out
    import pixel_stream_out_pkg::*;
#(
    parameter int IMG_W        = 640,
    parameter int IMG_H        = 480,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [23:0]            shade_in,
    output logic                   in_ready,
    output logic [AXIS_DATA_W-1:0] out_tdata,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic                   out_tuser,
    output logic                   out_tlast,
    output logic [15:0]            frame_count,
    output logic                   overflow_err
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] AFULL_LVL = CW'(FIFO_DEPTH - AFULL_MARGIN);

    ost_e                   state_q;
    ost_e                   state_d;
    logic                   xfer;
    logic                   pop;
    logic                   load;
    logic                   load_nxt;
    rgb24_t                 head_pix;
    rgb24_t                 nxt_pix;
    rgb24_t                 load_pix;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          occ;
    logic [CW-1:0]          occ_nxt;
    logic [AXIS_DATA_W-1:0] tdata_q;
    logic [XW-1:0]          x_q;
    logic [XW-1:0]          x_d;
    logic [YW-1:0]          y_q;
    logic [YW-1:0]          y_d;
    logic [15:0]            frame_q;
    logic [15:0]            frame_d;
    logic                   in_ready_q;
    logic                   ovf_q;
    logic                   last_x;
    logic                   last_y;

    // The presented beat stays in the FIFO until it transfers, so capacity is exactly FIFO_DEPTH.
    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(rgb24_t))
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (valid_in),
        .wr_dat_i     (shade_in),
        .rd_en_i      (pop),
        .rd_dat_o     (head_pix),
        .rd_nxt_dat_o (nxt_pix),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (occ),
        .count_nxt_o  (occ_nxt)
    );

    assign xfer = (state_q == ST_PRESENT) && out_tready;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!fifo_empty) state_d = ST_PRESENT;
            ST_PRESENT: if (out_tready && (occ <= CW'(1))) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        load     = 1'b0;
        load_nxt = 1'b0;
        case (state_q)
            ST_IDLE: load = !fifo_empty;
            ST_PRESENT: begin
                pop = out_tready;
                if (out_tready && (occ > CW'(1))) begin
                    load     = 1'b1;
                    load_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign load_pix = load_nxt ? nxt_pix : head_pix;

    always_ff @(posedge clk) begin
        if (!rst)      tdata_q <= '0;
        else if (load) tdata_q <= pack_axis(load_pix);
    end

    assign last_x = (x_q == XW'(IMG_W - 1));
    assign last_y = (y_q == YW'(IMG_H - 1));

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (xfer) begin
            if (last_x) begin
                x_d = '0;
                if (last_y) begin
                    y_d     = '0;
                    frame_d = frame_q + 16'd1;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            in_ready_q <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            in_ready_q <= (occ_nxt < AFULL_LVL);
            ovf_q      <= ovf_q | (valid_in && fifo_full && !xfer);
        end
    end

    // Framing flags follow the position counters, which only move on transfers.
    assign out_tvalid   = (state_q == ST_PRESENT);
    assign out_tdata    = tdata_q;
    assign out_tuser    = out_tvalid && (x_q == '0) && (y_q == '0);
    assign out_tlast    = out_tvalid && last_x;
    assign frame_count  = frame_q;
    assign overflow_err = ovf_q;
    assign in_ready     = in_ready_q;

endmodule
